// File: rtl/plru_miss_allocator_pkg.sv
// Shared definitions for the PLRU miss allocator: FSM encoding, width helper
// and the heap-indexed tree-PLRU walk/update functions.
package plru_miss_allocator_pkg;

  // Helpers work on a fixed maximum tree; callers zero-extend and slice.
  localparam int MAX_BW    = 8;
  localparam int MAX_NODES = (1 << MAX_BW) - 1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SELECT = 3'd1,
    ST_WB     = 3'd2,
    ST_FILL   = 3'd3,
    ST_COMMIT = 3'd4
  } state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Follow node bits from the root; the bits taken form the way index, MSB first.
  function automatic logic [MAX_BW-1:0] plru_walk(input logic [MAX_NODES-1:0] tree,
                                                  input int levels);
    int               node;
    logic [MAX_BW-1:0] way;
    node = 0;
    way  = '0;
    for (int lvl = 0; lvl < MAX_BW; lvl++) begin
      if (lvl < levels) begin
        way  = {way[MAX_BW-2:0], tree[node]};
        node = 2 * node + (tree[node] ? 2 : 1);
      end
    end
    return way;
  endfunction

  // Every node on the way's path is pointed away from it; others are untouched.
  function automatic logic [MAX_NODES-1:0] plru_update(input logic [MAX_NODES-1:0] tree,
                                                       input logic [MAX_BW-1:0]    way,
                                                       input int                   levels);
    logic [MAX_NODES-1:0] t;
    int                   node;
    int                   idx;
    logic                 b;
    t    = tree;
    node = 0;
    for (int lvl = 0; lvl < MAX_BW; lvl++) begin
      if (lvl < levels) begin
        idx     = levels - 1 - lvl;
        b       = way[idx];
        t[node] = ~b;
        node    = 2 * node + (b ? 2 : 1);
      end
    end
    return t;
  endfunction

endpackage

// File: rtl/plru_miss_allocator_tree_state.sv
// Tree-PLRU node register with a single reference-update port and the
// combinational pointer walk. Supports 2..128 ways.
module plru_tree_state
  import plru_miss_allocator_pkg::*;
#(
  parameter  int N_WAYS  = 8,
  localparam int BW_WAYS = clog2(N_WAYS)
) (
  input  logic               clock_i,
  input  logic               resetn_i,
  input  logic               update_en_i,
  input  logic [BW_WAYS-1:0] update_way_i,
  output logic [BW_WAYS-1:0] plru_way_o
);

  logic [N_WAYS-2:0]    tree_q, tree_d;
  logic [MAX_NODES-1:0] tree_ext, tree_upd;
  logic [MAX_BW-1:0]    way_ext, ptr_ext;
  logic                 unused_bits;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it holding its old value and no latch is inferred.
  always_comb begin
    tree_ext                 = '0;
    tree_ext[N_WAYS-2:0]     = tree_q;
    way_ext                  = '0;
    way_ext[BW_WAYS-1:0]     = update_way_i;
    tree_upd                 = plru_update(tree_ext, way_ext, BW_WAYS);
    ptr_ext                  = plru_walk(tree_ext, BW_WAYS);
    tree_d                   = update_en_i ? tree_upd[N_WAYS-2:0] : tree_q;
  end

  assign plru_way_o  = ptr_ext[BW_WAYS-1:0];
  assign unused_bits = ^{tree_upd[MAX_NODES-1:N_WAYS-1], ptr_ext[MAX_BW-1:BW_WAYS]};

  // NOTE: sequential state uses non-blocking assignment so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) tree_q <= '0;
    else           tree_q <= tree_d;
  end

endmodule

// File: rtl/plru_miss_allocator.sv
// Miss-side allocation controller: picks a victim (first invalid way, else
// PLRU), sequences optional writeback and fill, then commits the new line.
module plru_miss_allocator
  import plru_miss_allocator_pkg::*;
#(
  parameter  int N_WAYS  = 8,
  localparam int BW_WAYS = clog2(N_WAYS)
) (
  input  logic               clock_i,
  input  logic               resetn_i,
  input  logic               hit_i,
  input  logic [BW_WAYS-1:0] hit_way_i,
  input  logic [N_WAYS-1:0]  valid_i,
  input  logic [N_WAYS-1:0]  dirty_i,
  input  logic               miss_req_i,
  output logic               miss_ack_o,
  output logic [BW_WAYS-1:0] victim_way_o,
  output logic               wb_req_o,
  input  logic               wb_done_i,
  output logic               fill_req_o,
  input  logic               fill_done_i,
  output logic               busy_o
);

  state_e             state_q;
  logic [BW_WAYS-1:0] victim_q;
  logic               wb_req_q, fill_req_q, ack_q, busy_q;

  logic [BW_WAYS-1:0] plru_way;
  logic [BW_WAYS-1:0] first_invalid;
  logic               any_invalid;
  logic [BW_WAYS-1:0] sel_way;
  logic               sel_dirty;
  logic               upd_en;
  logic [BW_WAYS-1:0] upd_way;

  // Scan downward so the last assignment wins with the lowest invalid index.
  always_comb begin
    first_invalid = '0;
    any_invalid   = 1'b0;
    for (int w = N_WAYS - 1; w >= 0; w--) begin
      if (!valid_i[w]) begin
        any_invalid   = 1'b1;
        first_invalid = BW_WAYS'(w);
      end
    end
    sel_way   = any_invalid ? first_invalid : plru_way;
    sel_dirty = valid_i[sel_way] & dirty_i[sel_way];
  end

  // The commit reference wins the single update port; a hit in COMMIT is dropped.
  always_comb begin
    upd_en  = hit_i;
    upd_way = hit_way_i;
    if (state_q == ST_COMMIT) begin
      upd_en  = 1'b1;
      upd_way = victim_q;
    end
  end

  plru_tree_state #(.N_WAYS(N_WAYS)) u_tree (
    .clock_i      (clock_i),
    .resetn_i     (resetn_i),
    .update_en_i  (upd_en),
    .update_way_i (upd_way),
    .plru_way_o   (plru_way)
  );

  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q    <= ST_IDLE;
      victim_q   <= '0;
      wb_req_q   <= 1'b0;
      fill_req_q <= 1'b0;
      ack_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (miss_req_i) begin
            state_q <= ST_SELECT;
            busy_q  <= 1'b1;
          end
        end
        ST_SELECT: begin
          victim_q <= sel_way;
          if (sel_dirty) begin
            state_q  <= ST_WB;
            wb_req_q <= 1'b1;
          end else begin
            state_q    <= ST_FILL;
            fill_req_q <= 1'b1;
          end
        end
        ST_WB: begin
          if (wb_done_i) begin
            state_q    <= ST_FILL;
            wb_req_q   <= 1'b0;
            fill_req_q <= 1'b1;
          end
        end
        ST_FILL: begin
          if (fill_done_i) begin
            state_q    <= ST_COMMIT;
            fill_req_q <= 1'b0;
            ack_q      <= 1'b1;
          end
        end
        ST_COMMIT: begin
          state_q <= ST_IDLE;
          ack_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q    <= ST_IDLE;
          wb_req_q   <= 1'b0;
          fill_req_q <= 1'b0;
          ack_q      <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign miss_ack_o   = ack_q;
  assign victim_way_o = victim_q;
  assign wb_req_o     = wb_req_q;
  assign fill_req_o   = fill_req_q;
  assign busy_o       = busy_q;

endmodule

// File: tb/tb_plru_miss_allocator.sv
// Bench for plru_miss_allocator: per-cycle comparison against a behavioural
// cache-allocation model, plus directed scenarios with hand-derived victims.
module tb_plru_miss_allocator;

  localparam int N  = 8;
  localparam int BW = 3;

  localparam int M_IDLE   = 0;
  localparam int M_SELECT = 1;
  localparam int M_WB     = 2;
  localparam int M_FILL   = 3;
  localparam int M_COMMIT = 4;

  logic          clock_i = 1'b0;
  logic          resetn_i;
  logic          hit_i;
  logic [BW-1:0] hit_way_i;
  logic [N-1:0]  valid_i;
  logic [N-1:0]  dirty_i;
  logic          miss_req_i;
  logic          miss_ack_o;
  logic [BW-1:0] victim_way_o;
  logic          wb_req_o;
  logic          wb_done_i;
  logic          fill_req_o;
  logic          fill_done_i;
  logic          busy_o;

  plru_miss_allocator #(.N_WAYS(N)) dut (
    .clock_i      (clock_i),
    .resetn_i     (resetn_i),
    .hit_i        (hit_i),
    .hit_way_i    (hit_way_i),
    .valid_i      (valid_i),
    .dirty_i      (dirty_i),
    .miss_req_i   (miss_req_i),
    .miss_ack_o   (miss_ack_o),
    .victim_way_o (victim_way_o),
    .wb_req_o     (wb_req_o),
    .wb_done_i    (wb_done_i),
    .fill_req_o   (fill_req_o),
    .fill_done_i  (fill_done_i),
    .busy_o       (busy_o)
  );

  always #5 clock_i = ~clock_i;

  int checks = 0;
  int errors = 0;

  // Reference model: controller phase, latched victim, PLRU node bits.
  int m_state  = M_IDLE;
  int m_victim = 0;
  bit m_tree [0:N-2];
  logic s_wb, s_fill, s_ack;

  function automatic int plru_ptr();
    int node, way, b;
    node = 0;
    way  = 0;
    for (int lvl = 0; lvl < BW; lvl++) begin
      b    = int'(m_tree[node]);
      way  = way * 2 + b;
      node = 2 * node + 1 + b;
    end
    return way;
  endfunction

  function automatic void ref_update(input int w);
    int node, b;
    node = 0;
    for (int lvl = 0; lvl < BW; lvl++) begin
      b            = (w >> (BW - 1 - lvl)) & 1;
      m_tree[node] = (b == 0);
      node         = 2 * node + 1 + b;
    end
  endfunction

  function automatic int pick_victim();
    for (int i = 0; i < N; i++) if (!valid_i[i]) return i;
    return plru_ptr();
  endfunction

  function automatic void model_reset();
    m_state  = M_IDLE;
    m_victim = 0;
    for (int i = 0; i < N - 1; i++) m_tree[i] = 1'b0;
  endfunction

  function automatic void model_step();
    bit commit;
    commit = (m_state == M_COMMIT);
    case (m_state)
      M_IDLE:   if (miss_req_i) m_state = M_SELECT;
      M_SELECT: begin
        m_victim = pick_victim();
        m_state  = (valid_i[m_victim] && dirty_i[m_victim]) ? M_WB : M_FILL;
      end
      M_WB:     if (wb_done_i) m_state = M_FILL;
      M_FILL:   if (fill_done_i) m_state = M_COMMIT;
      default:  m_state = M_IDLE;
    endcase
    if (commit)     ref_update(m_victim);
    else if (hit_i) ref_update(int'(hit_way_i));
  endfunction

  task automatic check_outputs(input string tag);
    logic [6:0] got, want;
    got  = {busy_o, wb_req_o, fill_req_o, miss_ack_o, victim_way_o};
    want = {m_state != M_IDLE, m_state == M_WB, m_state == M_FILL,
            m_state == M_COMMIT, 3'(m_victim)};
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s outputs{busy,wb,fill,ack,victim}: got %b want %b at %0t",
               tag, got, want, $time);
    end
  endtask

  // Compare at negedge, then advance the model with the inputs seen at posedge.
  task automatic tick(input string tag);
    @(negedge clock_i);
    check_outputs(tag);
    s_wb   = wb_req_o;
    s_fill = fill_req_o;
    s_ack  = miss_ack_o;
    @(posedge clock_i);
    model_step();
    #1;
  endtask

  task automatic idle_inputs();
    hit_i       = 1'b0;
    hit_way_i   = '0;
    miss_req_i  = 1'b0;
    wb_done_i   = 1'b0;
    fill_done_i = 1'b0;
  endtask

  // Reset is dropped mid-cycle; outputs must clear before any clock edge.
  task automatic apply_reset();
    #1;
    resetn_i = 1'b0;
    idle_inputs();
    #1;
    checks++;
    if ({busy_o, wb_req_o, fill_req_o, miss_ack_o, victim_way_o} !== 7'b0) begin
      errors++;
      $display("FAIL async_reset: got %b want 0000000",
               {busy_o, wb_req_o, fill_req_o, miss_ack_o, victim_way_o});
    end
    model_reset();
    repeat (2) @(posedge clock_i);
    #3 resetn_i = 1'b1;
    @(posedge clock_i);
    #1;
  endtask

  task automatic do_miss(input int wb_wait, input int fill_wait, input bit rand_hits,
                         output int lat, output int wb_cyc, output int fill_cyc);
    int wb_cnt, fill_cnt;
    wb_cnt   = 0;
    fill_cnt = 0;
    lat      = -1;
    wb_cyc   = 0;
    fill_cyc = 0;
    miss_req_i = 1'b1;
    tick("miss_req");
    for (int k = 1; k <= 200 && lat < 0; k++) begin
      wb_done_i   = 1'b0;
      fill_done_i = 1'b0;
      if (m_state == M_WB) begin
        wb_done_i = (wb_cnt == wb_wait);
        wb_cnt++;
      end else if (rand_hits) begin
        wb_done_i = ($urandom_range(0, 3) == 0);
      end
      if (m_state == M_FILL) begin
        fill_done_i = (fill_cnt == fill_wait);
        fill_cnt++;
      end else if (rand_hits) begin
        fill_done_i = ($urandom_range(0, 3) == 0);
      end
      if (rand_hits) begin
        hit_i     = 1'($urandom_range(0, 1));
        hit_way_i = 3'($urandom_range(0, N - 1));
      end
      if (m_state == M_COMMIT) miss_req_i = 1'b0;
      tick("miss");
      if (s_wb)   wb_cyc++;
      if (s_fill) fill_cyc++;
      if (s_ack)  lat = k;
    end
    idle_inputs();
    if (lat < 0) begin
      checks++;
      errors++;
      $display("FAIL miss_timeout: got no ack want ack within 200 cycles");
    end
  endtask

  task automatic expect_int(input string tag, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", tag, got, want);
    end
  endtask

  task automatic test_reset();
    resetn_i = 1'b1;
    valid_i  = '1;
    dirty_i  = '0;
    idle_inputs();
    @(posedge clock_i);
    #1;
    apply_reset();
    tick("reset_idle");
    expect_int("reset_victim", int'(victim_way_o), 0);
  endtask

  task automatic test_invalid_pref();
    int lat, wbc, flc;
    apply_reset();
    valid_i = 8'b0000_0111;
    dirty_i = 8'hFF;
    do_miss(0, 0, 1'b0, lat, wbc, flc);
    expect_int("invalid_victim", int'(victim_way_o), 3);
    expect_int("invalid_latency", lat, 3);
    expect_int("invalid_wb_cycles", wbc, 0);
    expect_int("invalid_fill_cycles", flc, 1);
  endtask

  task automatic test_plru_order();
    int lat, wbc, flc;
    apply_reset();
    valid_i = '1;
    dirty_i = '0;
    for (int w = 0; w < N; w++) begin
      hit_i     = 1'b1;
      hit_way_i = 3'(w);
      tick("hit_seq");
    end
    hit_i = 1'b0;
    do_miss(0, 0, 1'b0, lat, wbc, flc);
    expect_int("plru_first_victim", int'(victim_way_o), 0);
    do_miss(0, 1, 1'b0, lat, wbc, flc);
    expect_int("plru_second_victim", int'(victim_way_o), 4);
    expect_int("plru_fill_wait_latency", lat, 4);
  endtask

  task automatic test_dirty_victim();
    int lat, wbc, flc;
    apply_reset();
    valid_i = '1;
    dirty_i = '1;
    do_miss(4, 0, 1'b0, lat, wbc, flc);
    expect_int("dirty_wb_cycles", wbc, 5);
    expect_int("dirty_fill_cycles", flc, 1);
    expect_int("dirty_latency", lat, 8);
    expect_int("dirty_victim", int'(victim_way_o), 0);
  endtask

  task automatic test_reset_in_fill();
    int lat, wbc, flc;
    apply_reset();
    valid_i   = '1;
    dirty_i   = '0;
    hit_i     = 1'b1;
    hit_way_i = 3'd0;
    tick("pre_hit");
    hit_i      = 1'b0;
    miss_req_i = 1'b1;
    tick("to_select");
    tick("to_fill");
    expect_int("in_fill_req", int'(fill_req_o), 1);
    apply_reset();
    do_miss(0, 0, 1'b0, lat, wbc, flc);
    expect_int("reissue_victim", int'(victim_way_o), 0);
  endtask

  task automatic run_commit_of_way2(input bit hit_in_fill);
    valid_i    = 8'b1111_1011;
    dirty_i    = '0;
    miss_req_i = 1'b1;
    tick("prio_idle");
    tick("prio_select");
    fill_done_i = 1'b1;
    if (hit_in_fill) begin
      hit_i     = 1'b1;
      hit_way_i = 3'd5;
    end
    tick("prio_fill");
    fill_done_i = 1'b0;
    miss_req_i  = 1'b0;
    hit_i       = !hit_in_fill;
    hit_way_i   = 3'd5;
    tick("prio_commit");
    hit_i   = 1'b0;
    valid_i = '1;
  endtask

  task automatic test_priority();
    int lat, wbc, flc;
    apply_reset();
    run_commit_of_way2(1'b0);
    do_miss(0, 0, 1'b0, lat, wbc, flc);
    expect_int("hit_in_commit_dropped", int'(victim_way_o), 4);
    apply_reset();
    run_commit_of_way2(1'b1);
    do_miss(0, 0, 1'b0, lat, wbc, flc);
    expect_int("hit_in_fill_applied", int'(victim_way_o), 6);
  endtask

  task automatic test_back_to_back();
    int acks;
    apply_reset();
    acks        = 0;
    valid_i     = '1;
    dirty_i     = 8'($urandom());
    miss_req_i  = 1'b1;
    wb_done_i   = 1'b1;
    fill_done_i = 1'b1;
    for (int c = 0; c < 16; c++) begin
      tick("back_to_back");
      if (s_ack) acks++;
    end
    idle_inputs();
    checks++;
    if (acks < 3) begin
      errors++;
      $display("FAIL back_to_back_acks: got %0d want at least 3", acks);
    end
    repeat (6) tick("b2b_drain");
  endtask

  task automatic test_random();
    int lat, wbc, flc;
    apply_reset();
    for (int it = 0; it < 30; it++) begin
      valid_i = ($urandom_range(0, 2) == 0) ? 8'($urandom()) : 8'hFF;
      dirty_i = 8'($urandom());
      for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
        hit_i       = 1'($urandom_range(0, 1));
        hit_way_i   = 3'($urandom_range(0, N - 1));
        wb_done_i   = 1'($urandom_range(0, 1));
        fill_done_i = 1'($urandom_range(0, 1));
        tick("rand_idle");
      end
      idle_inputs();
      do_miss(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b1, lat, wbc, flc);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish want finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_invalid_pref();
    test_plru_order();
    test_dirty_victim();
    test_reset_in_fill();
    test_priority();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
